// File: rtl/delay_pkg.sv
// Shared types for the multi-channel delay/tick generator.
package delay_pkg;

  typedef enum logic {
    PERIODIC = 1'b0,
    ONESHOT  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/delay_chan.sv
// One delay channel: programmable counter with tick strobe, shadowed period
// updates and a sticky error for a pending config overwritten before use.
module delay_chan
  import delay_pkg::*;
#(
  parameter int CBITS          = 16,
  parameter int DEFAULT_PERIOD = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CBITS-1:0] cfg_period,
  input  logic             cfg_mode,
  output logic             tick,
  output logic             busy,
  output logic             err
);

  state_e             state_q, state_d;
  logic [CBITS-1:0]   cnt_q, cnt_d;
  logic [CBITS-1:0]   period_q, period_d;
  mode_e              mode_q, mode_d;
  logic [CBITS-1:0]   pend_period_q, pend_period_d;
  mode_e              pend_mode_q, pend_mode_d;
  logic               pend_vld_q, pend_vld_d;
  logic               err_q, err_d;

  logic               tick_c;
  logic               apply;
  logic               direct;
  logic               shadow;
  logic               pend_vld_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      period_q      <= CBITS'(DEFAULT_PERIOD);
      mode_q        <= PERIODIC;
      pend_period_q <= '0;
      pend_mode_q   <= PERIODIC;
      pend_vld_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      mode_q        <= mode_d;
      pend_period_q <= pend_period_d;
      pend_mode_q   <= pend_mode_d;
      pend_vld_q    <= pend_vld_d;
      err_q         <= err_d;
    end
  end

  // A write lands in the live registers only when no interval is in flight
  // (or the current one ends at this edge); otherwise it waits in the shadow.
  always_comb begin
    tick_c      = (state_q == COUNT) && (cnt_q == period_q);
    apply       = (state_q == COUNT) && (tick_c || !en);
    direct      = wr && ((state_q != COUNT) || tick_c);
    shadow      = wr && !direct;
    pend_vld_in = pend_vld_q || shadow;

    pend_period_d = shadow ? cfg_period : pend_period_q;
    pend_mode_d   = shadow ? mode_e'(cfg_mode) : pend_mode_q;
    pend_vld_d    = apply ? 1'b0 : pend_vld_in;
    err_d         = err_q || (shadow && pend_vld_q);

    period_d = period_q;
    mode_d   = mode_q;
    if (direct) begin
      period_d = cfg_period;
      mode_d   = mode_e'(cfg_mode);
    end else if (apply && pend_vld_in) begin
      period_d = pend_period_d;
      mode_d   = pend_mode_d;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = COUNT;
          cnt_d   = '0;
        end
      end
      COUNT: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick_c) begin
          cnt_d = '0;
          if (mode_q == ONESHOT) state_d = DONE;
        end else begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end
      DONE: begin
        if (!en) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign tick = tick_c;
  assign busy = (state_q == COUNT);
  assign err  = err_q;

endmodule

// File: rtl/delay_bank.sv
// Bank of NCH independent delay channels sharing one config write port;
// writes addressed past the last channel are dropped and flagged.
module delay_bank
  import delay_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int CBITS          = 16,
  parameter int DEFAULT_PERIOD = 50000,
  localparam int CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [CBITS-1:0] cfg_period,
  input  logic             cfg_mode,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   err,
  output logic             cfg_err
);

  logic [NCH-1:0] ch_hit;
  logic           cfg_err_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign ch_hit[i] = (cfg_ch == CHW'(i));

    delay_chan #(
      .CBITS         (CBITS),
      .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (en[i]),
      .wr        (cfg_we && ch_hit[i]),
      .cfg_period(cfg_period),
      .cfg_mode  (cfg_mode),
      .tick      (tick[i]),
      .busy      (busy[i]),
      .err       (err[i])
    );
  end

  // Decoding by match rather than a range compare keeps this valid when NCH
  // is a power of two and no out-of-range address exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err_q <= 1'b0;
    else if (cfg_we && !(|ch_hit)) cfg_err_q <= 1'b1;
  end

  assign cfg_err = cfg_err_q;

endmodule

// File: doc/delay_bank.md
# delay_bank

Multi-channel programmable delay/tick generator: the parametrised successor of the single fixed-N delay counter. Each of NCH independent channels counts a run-time programmable period and emits a one-cycle tick, in either periodic or one-shot mode. Period changes are shadowed so that an in-flight interval is never corrupted. It sits between the control register block (config writes) and consumers that need timed strobes.

## Interface
- NCH, 4: number of channels (≥1)
- CBITS, 16: counter/period width
- DEFAULT_PERIOD, 50000: period loaded on reset (must fit in CBITS)
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- en  in  NCH  per-channel run enable (level)
- cfg_we  in  1  config write strobe
- cfg_ch  in  max(1,$clog2(NCH))  target channel
- cfg_period  in  CBITS  new period P
- cfg_mode  in  1  0 = PERIODIC, 1 = ONESHOT
- tick  out  NCH  one-cycle strobe per completed interval
- busy  out  NCH  channel in COUNT
- err  out  NCH  sticky: pending config overwritten before it was applied
- cfg_err  out  1  sticky: write with cfg_ch ≥ NCH

## Operation
- Per channel: regs period, mode, cnt, pend_period, pend_mode, pend_vld, state ∈ {IDLE, COUNT, DONE}.
- IDLE: busy=0. en=1 → COUNT, cnt=0.
- COUNT: busy=1; cnt+1 each cycle. tick = (state==COUNT && cnt==period), decoded from flops, no input path. On the tick cycle, PERIODIC → cnt=0, stay COUNT; ONESHOT → DONE. en=0 in COUNT → IDLE, cnt=0, no tick (en=0 on tick cycle: tick still asserts, next state IDLE).
- DONE: busy=0, tick=0; en=0 → IDLE. Re-arm requires an en low→high cycle.
- Interval = P+1 cycles; P=0 ticks every cycle in PERIODIC.
- Config write, channel in IDLE or DONE, or in COUNT on its tick cycle: period/mode load directly at that edge; pend_vld unchanged.
- Config write, channel in COUNT, not tick cycle: store in pend_*, pend_vld=1. If pend_vld already 1: overwrite with newest values, set err[ch].
- Pending applied at the edge ending a tick cycle (PERIODIC wrap or ONESHOT→DONE), or at the COUNT→IDLE edge; pend_vld cleared.
- cfg_ch ≥ NCH: write ignored, cfg_err=1.
- err, cfg_err cleared only by rst.
- Counter never exceeds period: the shadowing guarantees cnt ≤ period.

## Timing
- Reset (async assert): state=IDLE, cnt=0, period=DEFAULT_PERIOD, mode=PERIODIC, pend_vld=0; tick=0, busy=0, err=0, cfg_err=0. Deassertion is synchronous to clk externally.
- en sampled high at edge k (IDLE): busy from k; ticks in cycles after edges k+P, k+2P+1, … (PERIODIC).
- Config to tick: direct load affects the decode in the cycle after the write edge.
- Same-edge IDLE en rise + config write: new period governs the first interval.
- rst mid-COUNT: all channels abort immediately, no tick, pending discarded.
- Channels fully independent; simultaneous ticks allowed.

## Structure
- delay_pkg: mode_e {PERIODIC, ONESHOT}, state_e {IDLE, COUNT, DONE}.
- Sub-module delay_chan (one channel: FSM, counter, shadow regs, err); delay_bank instantiates NCH via generate and decodes cfg_ch / cfg_err.

## Test plan
- Reset, en[0]=1, no config → tick[0] every 50001 cycles, busy[0]=1, err=0.
- Write ch1 P=3 PERIODIC in IDLE, en[1] at edge k → tick[1] after k+3, k+7, k+11; deassert en → busy 0 next cycle, no further ticks.
- ch2 P=2 ONESHOT → single tick after k+2, then DONE busy=0; en held high → no more ticks; en low one cycle then high → one more tick.
- ch0 running P=9, write P=1 at cnt=4 → current interval still ticks at cnt=9, then ticks every 2 cycles; a second write before the wrap → err[0]=1, last value wins.
- cfg_ch=NCH write → cfg_err=1, no channel changes.
- Assert rst mid-count (cnt=5, pending valid) → outputs 0 immediately; after release period=50000, pend_vld=0.
